// File: rtl/rom_read_sequencer_if.sv
// ROM address/data bus and downstream valid/ready byte stream of the ROM read sequencer.
interface rom_read_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] address_line;
  logic                  rom_ce_n;
  logic                  rom_oe_n;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  busy;
  logic                  done;

  // Sequencer side
  modport master (
    input  start, rom_data, data_ready,
    output address_line, rom_ce_n, rom_oe_n, data_out, data_valid, busy, done
  );

  // ROM chip / consumer / controller side
  modport slave (
    output start, rom_data, data_ready,
    input  address_line, rom_ce_n, rom_oe_n, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/rom_read_sequencer.sv
// Sweeps ROM addresses 0..END_ADDRESS, waits ACCESS_CYCLES per location with
// strobes asserted, then hands each byte downstream over valid/ready.
module rom_read_sequencer #(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned END_ADDRESS   = 511,
  parameter int unsigned ACCESS_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  rom_read_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, HANDOFF, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(END_ADDRESS);
  localparam logic [3:0]            LAST_COUNT   = 4'(ACCESS_CYCLES - 1);

  state_t                state, state_nxt;
  logic [3:0]            count, count_nxt;
  logic [ADDR_WIDTH-1:0] address, address_nxt;
  logic                  ce_n, ce_n_nxt;
  logic                  oe_n, oe_n_nxt;
  logic [DATA_WIDTH-1:0] data, data_nxt;
  logic                  valid, valid_nxt;
  logic                  busy, busy_nxt;
  logic                  done, done_nxt;

  // State and registered outputs; reset overrides everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      address <= '0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      address <= address_nxt;
      ce_n    <= ce_n_nxt;
      oe_n    <= oe_n_nxt;
      data    <= data_nxt;
      valid   <= valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = ACCESS;
      ACCESS:  if (count == LAST_COUNT) state_nxt = HANDOFF;
      HANDOFF: if (bus.data_ready) state_nxt = (address == LAST_ADDRESS) ? DONE : ACCESS;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the current state so
  // every output changes on the same edge as the state transition
  always_comb begin
    count_nxt   = count;
    address_nxt = address;
    ce_n_nxt    = ce_n;
    oe_n_nxt    = oe_n;
    data_nxt    = data;
    valid_nxt   = valid;
    busy_nxt    = busy;
    done_nxt    = done;
    unique case (state)
      IDLE: begin
        count_nxt   = '0;
        address_nxt = '0;
        ce_n_nxt    = 1'b1;
        oe_n_nxt    = 1'b1;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        if (bus.start) begin
          ce_n_nxt = 1'b0;
          oe_n_nxt = 1'b0;
          busy_nxt = 1'b1;
        end
      end
      ACCESS: begin
        count_nxt = count + 4'd1;
        if (count == LAST_COUNT) begin
          data_nxt  = bus.rom_data;
          valid_nxt = 1'b1;
        end
      end
      HANDOFF: begin
        if (bus.data_ready) begin
          valid_nxt = 1'b0;
          count_nxt = '0;
          // Compare before incrementing so a full-range END_ADDRESS stops
          // instead of rolling over to 0
          if (address == LAST_ADDRESS) begin
            address_nxt = '0;
            ce_n_nxt    = 1'b1;
            oe_n_nxt    = 1'b1;
            done_nxt    = 1'b1;
          end else begin
            address_nxt = address + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        count_nxt   = '0;
        address_nxt = '0;
        ce_n_nxt    = 1'b1;
        oe_n_nxt    = 1'b1;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
      end
      default: begin
        count_nxt   = '0;
        address_nxt = '0;
        ce_n_nxt    = 1'b1;
        oe_n_nxt    = 1'b1;
        valid_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.address_line = address;
  assign bus.rom_ce_n     = ce_n;
  assign bus.rom_oe_n     = oe_n;
  assign bus.data_out     = data;
  assign bus.data_valid   = valid;
  assign bus.busy         = busy;
  assign bus.done         = done;

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: one 512-location instance with 4-cycle access
// and one 4-location full-range instance with 1-cycle access.
module tb_rom_read_sequencer;

  logic clk;
  logic reset;

  rom_read_sequencer_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) a_if ();
  rom_read_sequencer_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) b_if ();

  // ROM models: byte = low address bits ^ 8'hA5
  assign a_if.rom_data = a_if.address_line[7:0] ^ 8'hA5;
  assign b_if.rom_data = {6'b0, b_if.address_line} ^ 8'hA5;

  rom_read_sequencer #(
    .ADDR_WIDTH(9), .DATA_WIDTH(8), .END_ADDRESS(511), .ACCESS_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );

  rom_read_sequencer #(
    .ADDR_WIDTH(2), .DATA_WIDTH(8), .END_ADDRESS(3), .ACCESS_CYCLES(1)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int a_hs   = 0;
  int a_done_n = 0;
  int b_done_n = 0;

  logic [16:0] qa[$];
  logic [16:0] qb[$];

  typedef struct {
    logic       rst, sa, sb, rdy, pa, pb, sel;
    logic       busy, valid, done, ce_n, oe_n;
    logic [8:0] addr;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, sa, sb, rdy, pa, pb, sel,
                              input logic busy, valid, done, ce_n, oe_n,
                              input logic [8:0] addr, input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.sa = sa; v.sb = sb; v.rdy = rdy; v.pa = pa; v.pb = pb; v.sel = sel;
    v.busy = busy; v.valid = valid; v.done = done; v.ce_n = ce_n; v.oe_n = oe_n;
    v.addr = addr; v.dout = dout;
    return v;
  endfunction

  task automatic push_sweep_a();
    for (int k = 0; k <= 511; k++) qa.push_back({9'(k), 8'(k) ^ 8'hA5});
  endtask

  task automatic push_sweep_b();
    for (int k = 0; k <= 3; k++) qb.push_back({9'(k), 8'(k) ^ 8'hA5});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted byte must be the next expected {address, byte}
  always @(negedge clk) begin
    if (!reset && a_if.data_valid && a_if.data_ready) begin
      a_hs++;
      if (qa.size() == 0) chk("a_sb_underflow", {15'b0, a_if.address_line, a_if.data_out}, 32'h1ffff);
      else chk("a_byte", {15'b0, a_if.address_line, a_if.data_out}, {15'b0, qa.pop_front()});
    end
    if (!reset && b_if.data_valid && b_if.data_ready) begin
      if (qb.size() == 0) chk("b_sb_underflow", {15'b0, 7'b0, b_if.address_line, b_if.data_out}, 32'h1ffff);
      else chk("b_byte", {15'b0, 7'b0, b_if.address_line, b_if.data_out}, {15'b0, qb.pop_front()});
    end
    if (!reset && a_if.done) a_done_n++;
    if (!reset && b_if.done) b_done_n++;
  end

  task automatic wait_a(input logic [8:0] addr, input logic want_valid, input int budget, input string name);
    int n = 0;
    while (!(a_if.address_line == addr && (!want_valid || a_if.data_valid)) && n < budget) begin
      step();
      n++;
    end
    chk(name, {31'b0, n < budget}, 32'd1);
  endtask

  task automatic check_vec(input int i, input vec_t v);
    if (v.sel == 1'b0) begin
      chk($sformatf("v%0d_busy", i), {31'b0, a_if.busy}, {31'b0, v.busy});
      chk($sformatf("v%0d_valid", i), {31'b0, a_if.data_valid}, {31'b0, v.valid});
      chk($sformatf("v%0d_done", i), {31'b0, a_if.done}, {31'b0, v.done});
      chk($sformatf("v%0d_strobes", i), {30'b0, a_if.rom_ce_n, a_if.rom_oe_n}, {30'b0, v.ce_n, v.oe_n});
      chk($sformatf("v%0d_addr", i), {23'b0, a_if.address_line}, {23'b0, v.addr});
      chk($sformatf("v%0d_dout", i), {24'b0, a_if.data_out}, {24'b0, v.dout});
    end else begin
      chk($sformatf("v%0d_busy", i), {31'b0, b_if.busy}, {31'b0, v.busy});
      chk($sformatf("v%0d_valid", i), {31'b0, b_if.data_valid}, {31'b0, v.valid});
      chk($sformatf("v%0d_done", i), {31'b0, b_if.done}, {31'b0, v.done});
      chk($sformatf("v%0d_strobes", i), {30'b0, b_if.rom_ce_n, b_if.rom_oe_n}, {30'b0, v.ce_n, v.oe_n});
      chk($sformatf("v%0d_addr", i), {30'b0, b_if.address_line}, {23'b0, v.addr});
      chk($sformatf("v%0d_dout", i), {24'b0, b_if.data_out}, {24'b0, v.dout});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [20:0] snap;
    int          n;

    reset = 1'b1;
    a_if.start = 1'b0; a_if.data_ready = 1'b0;
    b_if.start = 1'b0; b_if.data_ready = 1'b0;

    //               rst sa sb rdy pa pb sel  busy vld done ce oe  addr  dout
    // Instance A: reset, start, 4-cycle access, backpressure, next byte
    vecs.push_back(mk(1, 0, 0, 0,  0, 0, 0,   0,   0,  0,   1, 1,  0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,   0,   0,  0,   1, 1,  0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0,  1, 0, 0,   1,   0,  0,   0, 0,  0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   1,  0,   0, 0,  0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0,   1,   1,  0,   0, 0,  0, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   0,  0,   0, 0,  1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 1,  0, 0, 0,   1,   1,  0,   0, 0,  1, 8'hA4));
    vecs.push_back(mk(1, 0, 0, 1,  0, 0, 0,   0,   0,  0,   1, 1,  0, 8'h00));
    // Instance B: 1-cycle access, full-range END_ADDRESS=3, start held high
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1,   1,   0,  0,   0, 0,  0, 8'h00));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   1,  0,   0, 0,  0, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   0,  0,   0, 0,  1, 8'hA5));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   1,  0,   0, 0,  1, 8'hA4));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   0,  0,   0, 0,  2, 8'hA4));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   1,  0,   0, 0,  2, 8'hA7));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   0,  0,   0, 0,  3, 8'hA7));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   1,  0,   0, 0,  3, 8'hA6));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   0,  1,   1, 1,  0, 8'hA6));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   0,   0,  0,   1, 1,  0, 8'hA6));
    vecs.push_back(mk(0, 0, 1, 1,  0, 1, 1,   1,   0,  0,   0, 0,  0, 8'hA6));
    vecs.push_back(mk(0, 0, 1, 1,  0, 0, 1,   1,   1,  0,   0, 0,  0, 8'hA5));

    foreach (vecs[i]) begin
      reset           = vecs[i].rst;
      a_if.start      = vecs[i].sa;
      b_if.start      = vecs[i].sb;
      a_if.data_ready = vecs[i].rdy;
      b_if.data_ready = vecs[i].rdy;
      if (vecs[i].rst) begin
        qa.delete();
        qb.delete();
      end
      if (vecs[i].pa) push_sweep_a();
      if (vecs[i].pb) push_sweep_b();
      step();
      check_vec(i, vecs[i]);
    end
    chk("b_done_pulses", b_done_n, 1);

    reset = 1'b1; b_if.start = 1'b0; a_if.data_ready = 1'b0; b_if.data_ready = 1'b0;
    qa.delete(); qb.delete();
    step();
    reset = 1'b0;

    // Reset while stalled in HANDOFF at address 37
    a_if.start = 1'b1; push_sweep_a(); step(); a_if.start = 1'b0;
    a_if.data_ready = 1'b1;
    wait_a(9'd37, 1'b0, 400, "wait_addr37");
    a_if.data_ready = 1'b0;
    wait_a(9'd37, 1'b1, 20, "wait_valid37");
    reset = 1'b1; qa.delete();
    step();
    reset = 1'b0;
    chk("rst_mid_addr", {23'b0, a_if.address_line}, 32'd0);
    chk("rst_mid_strobes", {30'b0, a_if.rom_ce_n, a_if.rom_oe_n}, 32'd3);
    chk("rst_mid_valid", {31'b0, a_if.data_valid}, 32'd0);
    chk("rst_mid_busy", {31'b0, a_if.busy}, 32'd0);
    chk("rst_mid_dout", {24'b0, a_if.data_out}, 32'd0);
    step();
    chk("rst_idle_busy", {31'b0, a_if.busy}, 32'd0);

    // Restart from 0, backpressure at 3, stray start at 100, full sweep
    a_hs = 0; a_done_n = 0;
    a_if.start = 1'b1; push_sweep_a(); step(); a_if.start = 1'b0;
    chk("restart_addr", {23'b0, a_if.address_line}, 32'd0);
    chk("restart_busy", {31'b0, a_if.busy}, 32'd1);
    a_if.data_ready = 1'b1;
    wait_a(9'd3, 1'b0, 100, "wait_addr3");
    a_if.data_ready = 1'b0;
    wait_a(9'd3, 1'b1, 20, "wait_valid3");
    snap = {a_if.address_line, a_if.rom_ce_n, a_if.rom_oe_n, a_if.data_valid, a_if.data_out};
    chk("bp_byte", {24'b0, a_if.data_out}, 32'h000000A6);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("bp_hold%0d", c),
          {11'b0, a_if.address_line, a_if.rom_ce_n, a_if.rom_oe_n, a_if.data_valid, a_if.data_out},
          {11'b0, snap});
    end
    a_if.data_ready = 1'b1;
    wait_a(9'd100, 1'b0, 1000, "wait_addr100");
    a_if.start = 1'b1; step(); a_if.start = 1'b0;
    chk("start_busy_ignored", {23'b0, a_if.address_line}, 32'd100);

    n = 0;
    while (!a_if.done && n < 3000) begin
      step();
      n++;
    end
    chk("done_seen", {31'b0, a_if.done}, 32'd1);
    chk("done_busy", {31'b0, a_if.busy}, 32'd1);
    chk("done_addr", {23'b0, a_if.address_line}, 32'd0);
    chk("done_strobes", {30'b0, a_if.rom_ce_n, a_if.rom_oe_n}, 32'd3);
    chk("done_valid", {31'b0, a_if.data_valid}, 32'd0);
    step();
    chk("after_done", {31'b0, a_if.done}, 32'd0);
    chk("after_busy", {31'b0, a_if.busy}, 32'd0);
    chk("after_addr", {23'b0, a_if.address_line}, 32'd0);
    chk("handshakes", a_hs, 512);
    chk("sb_leftover", qa.size(), 0);
    for (int c = 0; c < 20; c++) step();
    chk("no_restart_busy", {31'b0, a_if.busy}, 32'd0);
    chk("no_restart_strobes", {30'b0, a_if.rom_ce_n, a_if.rom_oe_n}, 32'd3);
    chk("a_done_pulses", a_done_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
